seq_scan_ctrl: RTL and testbench
================================

# seq_scan_ctrl

Controller and scheduler for the team's bit-serial pattern-detection datapath. It accepts parallel words from an upstream requester over a valid/ready handshake and serializes them MSB-first into a programmable overlapping pattern detector. It counts matches across a multi-word frame and returns the count on a result handshake. It also owns the detector's configuration (pattern and length), which defaults to the team's standard 0110 detector.

## Interface
- WORD_W, 8, input word width (≥2)
- PAT_MAX, 8, maximum pattern length in bits
- CNT_W, 8, match-count width
- LEN_W, $clog2(PAT_MAX)+1, width of cfg_len (derived)

- clk  in  1  rising-edge clock
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- cfg_we  in  1  config write strobe
- cfg_pattern  in  PAT_MAX  pattern; bit[len-1] is the oldest bit, bit[0] the newest
- cfg_len  in  LEN_W  pattern length; legal range 1..PAT_MAX
- cfg_err  out  1  registered 1-cycle pulse when a config write is rejected
- in_valid / in_ready  in / out  1  word handshake
- in_data  in  WORD_W  word, shifted MSB first
- in_last  in  1  marks the final word of the frame
- det_hit  out  1  registered 1-cycle pulse per match
- res_valid / res_ready  out / in  1  result handshake
- res_count  out  CNT_W  matches in the frame, saturating
- res_overflow  out  1  count saturated
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States:
  - IDLE: no frame open; in_ready=1; config writes allowed.
  - SHIFT: serializing a word; in_ready=0.
  - GAP: mid-frame, waiting for the next word; in_ready=1; config writes rejected.
  - REPORT: res_valid=1; in_ready=0.
- Transitions:
  - IDLE/GAP → SHIFT on in_valid&in_ready. The word is latched and in_last is captured.
  - SHIFT → GAP after the WORD_W-th bit if the captured last bit is 0; SHIFT → REPORT if it is 1.
  - REPORT → IDLE on res_ready.
- Detector:
  - PAT_MAX-bit window shift register plus a fill counter that saturates at PAT_MAX.
  - Each shifted bit enters window[0].
  - A hit occurs when fill ≥ len and window[len-1:0] == pattern[len-1:0]. Overlapping matches are counted.
  - Window and fill persist across words in one frame. Matches spanning a word boundary count.
- Count: increments on each hit and saturates at 2^CNT_W−1. res_overflow sets if a hit occurs while the count is saturated.
- On REPORT→IDLE: count, overflow, window and fill are cleared. Config is retained.
- Config:
  - A write is accepted only in IDLE with 1 ≤ cfg_len ≤ PAT_MAX.
  - Otherwise the write is ignored and cfg_err pulses the next cycle.
  - cfg_we and an accepted word in the same IDLE cycle: both take effect, and the word is evaluated with the new config.
- Reset values:
  - state=IDLE, pattern=0110 (low bits), len=4.
  - All registered outputs are 0: det_hit, cfg_err, res_valid, res_count, res_overflow, busy.
  - in_ready=1.
- Reset asserted mid-frame aborts immediately. No result is emitted and config reverts to the default.

## Timing
- A word is accepted at edge E0. Bit k (k=0..WORD_W−1, MSB first) enters the window at edge E(k+1).
- det_hit is high in the cycle after the edge that produced the match. res_count reflects the match at that same edge.
- Last word: res_valid rises in the cycle after E(WORD_W), giving latency WORD_W+1 cycles from acceptance.
- Non-last word: in_ready=1 from the cycle after E(WORD_W). Minimum word spacing is WORD_W+1 cycles.
- res_count and res_overflow are stable while res_valid=1 and res_ready=0.
- in_ready and res_valid are decoded from state only, with no combinational path from inputs.

## Structure
- Shared package seq_pkg:
  - state encodings for IDLE, SHIFT, GAP and REPORT
  - DEFAULT_PATTERN=0110 and DEFAULT_LEN=4
- Sub-module pattern_window:
  - Contains the window shift register, fill counter and compare.
  - Inputs: shift_en, bit_in, clr, pattern, len. Output: hit.
- seq_scan_ctrl holds the FSM, word register, bit counter, config registers and match counter.

## Test plan
- Default config, single word 8'b0110_1100 with last=1 → det_hit twice (after bits 3 and 6), res_count=2, res_overflow=0, res_valid 9 cycles after accept.
- Word 8'b0000_0011 (last=0) then 8'b0000_0000 (last=1) → one cross-boundary match, res_count=1; in_ready=1 in GAP.
- cfg_len=3, pattern 3'b111, word 8'hFF → res_count=6; cfg_len=0 or cfg_we during SHIFT → cfg_err pulse, config unchanged.
- res_ready held low 5 cycles in REPORT → res_valid, res_count and busy held, in_ready=0; frame closes on res_ready and count clears for the next frame.
- CNT_W=2, cfg_len=1, pattern 1'b1, word 8'hFF → res_count=3, res_overflow=1.
- reset_n pulsed low during SHIFT → immediate IDLE, no res_valid, pattern/len back to 0110/4, in_ready=1.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the bit-serial pattern scan controller:
// FSM encodings, the default detector configuration and a compare-mask helper.
package seq_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b0110;
  localparam int         DEFAULT_LEN     = 4;

  // Low 'len' bits set; callers slice the result to the window width.
  function automatic logic [63:0] len_mask(input logic [6:0] len);
    logic [63:0] m;
    m = (64'd1 << len) - 64'd1;
    return m;
  endfunction

endpackage

// File: rtl/pattern_window.sv
// Sliding bit window with saturating fill counter and masked pattern compare.
// 'hit' reports the match that the pending shift will produce at the next edge.
module pattern_window
  import seq_pkg::*;
#(
  parameter int PAT_MAX = 8,
  parameter int LEN_W   = $clog2(PAT_MAX) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               shift_en,
  input  logic               bit_in,
  input  logic               clr,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [PAT_MAX-1:0] window_r;
  logic [LEN_W-1:0]   fill_r;
  logic [PAT_MAX-1:0] win_next_s;
  logic [LEN_W-1:0]   fill_next_s;
  logic [PAT_MAX-1:0] mask_s;

  // Next window/fill values and the match they would produce.
  always_comb begin
    win_next_s = {window_r[PAT_MAX-2:0], bit_in};
    mask_s     = PAT_MAX'(len_mask(7'(len)));
    if (fill_r == LEN_W'(PAT_MAX)) begin
      fill_next_s = fill_r;
    end else begin
      fill_next_s = fill_r + LEN_W'(1);
    end
    if (shift_en && (fill_next_s >= len) && (((win_next_s ^ pattern) & mask_s) == '0)) begin
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
  end

  // Window and fill persist across words until the frame is closed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      window_r <= '0;
      fill_r   <= '0;
    end else if (clr) begin
      window_r <= '0;
      fill_r   <= '0;
    end else if (shift_en) begin
      window_r <= win_next_s;
      fill_r   <= fill_next_s;
    end else begin
      window_r <= window_r;
      fill_r   <= fill_r;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Frame controller: accepts words, serializes them MSB first into the
// pattern window, counts matches and returns the count on a result handshake.
module seq_scan_ctrl
  import seq_pkg::*;
#(
  parameter int WORD_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(PAT_MAX) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  output logic               cfg_err,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_last,
  output logic               det_hit,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CNT_W-1:0]   res_count,
  output logic               res_overflow,
  output logic               busy
);

  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]         state_r;
  logic [1:0]         state_next_s;
  logic [WORD_W-1:0]  word_r;
  logic               last_r;
  logic [BIT_W-1:0]   bit_cnt_r;
  logic [PAT_MAX-1:0] pattern_r;
  logic [LEN_W-1:0]   len_r;
  logic [CNT_W-1:0]   count_r;
  logic               ovf_r;
  logic               det_hit_r;
  logic               cfg_err_r;

  logic accept_s;
  logic shift_s;
  logic last_bit_s;
  logic close_s;
  logic cfg_ok_s;
  logic hit_s;

  assign in_ready     = (state_r == ST_IDLE) || (state_r == ST_GAP);
  assign res_valid    = (state_r == ST_REPORT);
  assign busy         = (state_r != ST_IDLE);
  assign res_count    = count_r;
  assign res_overflow = ovf_r;
  assign det_hit      = det_hit_r;
  assign cfg_err      = cfg_err_r;

  assign accept_s   = in_valid && in_ready;
  assign shift_s    = (state_r == ST_SHIFT);
  assign last_bit_s = shift_s && (bit_cnt_r == BIT_W'(WORD_W - 1));
  assign close_s    = (state_r == ST_REPORT) && res_ready;
  assign cfg_ok_s   = cfg_we && (state_r == ST_IDLE) &&
                      (cfg_len >= LEN_W'(1)) && (cfg_len <= LEN_W'(PAT_MAX));

  pattern_window #(
    .PAT_MAX (PAT_MAX),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift_en (shift_s),
    .bit_in   (word_r[WORD_W-1]),
    .clr      (close_s),
    .pattern  (pattern_r),
    .len      (len_r),
    .hit      (hit_s)
  );

  // Frame sequencing.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:   state_next_s = accept_s ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: begin
        if (last_bit_s) begin
          state_next_s = last_r ? ST_REPORT : ST_GAP;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_GAP:    state_next_s = accept_s ? ST_SHIFT : ST_GAP;
      ST_REPORT: state_next_s = res_ready ? ST_IDLE : ST_REPORT;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // State, word shifter and bit counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      word_r    <= '0;
      last_r    <= 1'b0;
      bit_cnt_r <= '0;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        word_r    <= in_data;
        last_r    <= in_last;
        bit_cnt_r <= '0;
      end else if (shift_s) begin
        word_r    <= word_r << 1;
        bit_cnt_r <= last_bit_s ? '0 : bit_cnt_r + BIT_W'(1);
      end else begin
        word_r    <= word_r;
        bit_cnt_r <= bit_cnt_r;
      end
    end
  end

  // Detector configuration; rejected writes flag an error the next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_r <= PAT_MAX'(DEFAULT_PATTERN);
      len_r     <= LEN_W'(DEFAULT_LEN);
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= cfg_we && !cfg_ok_s;
      if (cfg_ok_s) begin
        pattern_r <= cfg_pattern;
        len_r     <= cfg_len;
      end else begin
        pattern_r <= pattern_r;
        len_r     <= len_r;
      end
    end
  end

  // Saturating match count, sticky overflow and hit pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r   <= '0;
      ovf_r     <= 1'b0;
      det_hit_r <= 1'b0;
    end else begin
      det_hit_r <= hit_s;
      if (close_s) begin
        count_r <= '0;
        ovf_r   <= 1'b0;
      end else if (hit_s) begin
        if (count_r == CNT_MAX) begin
          ovf_r <= 1'b1;
        end else begin
          count_r <= count_r + CNT_W'(1);
        end
      end else begin
        count_r <= count_r;
        ovf_r   <= ovf_r;
      end
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: a frame table plus hand-written corner sequences.
// A second instance with a 2-bit count shares all inputs to exercise saturation.
module tb_seq_scan_ctrl;

  localparam int WORD_W = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       res_ready;

  logic       cfg_err, in_ready, det_hit, res_valid, res_overflow, busy;
  logic [7:0] res_count;
  logic       cfg_err2, in_ready2, det_hit2, res_valid2, res_overflow2, busy2;
  logic [1:0] res_count2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_scan_ctrl #(.WORD_W(8), .PAT_MAX(8), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .det_hit(det_hit), .res_valid(res_valid),
    .res_ready(res_ready), .res_count(res_count), .res_overflow(res_overflow), .busy(busy)
  );

  seq_scan_ctrl #(.WORD_W(8), .PAT_MAX(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_err(cfg_err2), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .det_hit(det_hit2), .res_valid(res_valid2),
    .res_ready(res_ready), .res_count(res_count2), .res_overflow(res_overflow2), .busy(busy2)
  );

  typedef struct {
    logic       cfg;
    logic [7:0] pat;
    logic [3:0] len;
    int         nw;
    logic [7:0] w0;
    logic [7:0] w1;
    int         hits;
    logic [7:0] cnt;
    logic       ovf;
    logic [1:0] cnt2;
    logic       ovf2;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic close_frame(input string tag);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({tag, ":closed_valid"}, res_valid, 0);
    chk({tag, ":closed_busy"}, busy, 0);
    chk({tag, ":closed_ready"}, in_ready, 1);
    chk({tag, ":closed_count"}, res_count, 0);
    chk({tag, ":closed_ovf"}, res_overflow, 0);
    chk({tag, ":closed_count2"}, res_count2, 0);
  endtask

  // Optional config write in the acceptance cycle of the first word.
  task automatic run_frame(input vec_t v, input string tag);
    int hits;
    int cyc;
    bit done;
    hits = 0;
    @(negedge clk);
    if (v.cfg) begin
      cfg_we = 1'b1; cfg_pattern = v.pat; cfg_len = v.len;
    end
    for (int w = 0; w < v.nw; w++) begin
      in_valid = 1'b1;
      in_data  = (w == 0) ? v.w0 : v.w1;
      in_last  = (w == v.nw - 1);
      @(posedge clk); #1;
      in_valid = 1'b0; cfg_we = 1'b0;
      if (w == 0) chk({tag, ":cfg_err"}, cfg_err, 0);
      chk({tag, ":shift_ready"}, in_ready, 0);
      cyc = 0; done = 1'b0;
      while (!done && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
        if (det_hit) hits++;
        if (w == v.nw - 1) done = res_valid;
        else done = in_ready;
      end
      chk({tag, ":latency"}, cyc, WORD_W);
      if (w < v.nw - 1) begin
        chk({tag, ":gap_ready"}, in_ready, 1);
        chk({tag, ":gap_busy"}, busy, 1);
      end
    end
    chk({tag, ":hits"}, hits, v.hits);
    for (int i = 0; i < 5; i++) begin
      chk({tag, ":rep_valid"}, res_valid, 1);
      chk({tag, ":rep_ready"}, in_ready, 0);
      chk({tag, ":rep_busy"}, busy, 1);
      chk({tag, ":count"}, res_count, v.cnt);
      chk({tag, ":ovf"}, res_overflow, v.ovf);
      @(posedge clk); #1;
    end
    chk({tag, ":count2"}, res_count2, v.cnt2);
    chk({tag, ":ovf2"}, res_overflow2, v.ovf2);
    close_frame(tag);
  endtask

  initial begin
    int cyc;
    vec_t v;
    tbl[0] = '{1'b0, 8'h00, 4'd0, 2, 8'h6C, 8'h00, 2, 8'd2, 1'b0, 2'd2, 1'b0};
    tbl[0].nw = 1;
    tbl[1] = '{1'b0, 8'h00, 4'd0, 2, 8'h03, 8'h00, 1, 8'd1, 1'b0, 2'd1, 1'b0};
    tbl[2] = '{1'b1, 8'h07, 4'd3, 1, 8'hFF, 8'h00, 6, 8'd6, 1'b0, 2'd3, 1'b1};
    tbl[3] = '{1'b1, 8'hA5, 4'd8, 1, 8'hA5, 8'h00, 1, 8'd1, 1'b0, 2'd1, 1'b0};
    tbl[4] = '{1'b1, 8'h06, 4'd4, 2, 8'h66, 8'h66, 4, 8'd4, 1'b0, 2'd3, 1'b1};
    tbl[5] = '{1'b1, 8'h02, 4'd2, 1, 8'hAA, 8'h00, 4, 8'd4, 1'b0, 2'd3, 1'b1};
    tbl[6] = '{1'b1, 8'h01, 4'd1, 1, 8'hFF, 8'h00, 8, 8'd8, 1'b0, 2'd3, 1'b1};

    reset_n = 1'b0; cfg_we = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst:in_ready", in_ready, 1);
    chk("rst:res_valid", res_valid, 0);
    chk("rst:busy", busy, 0);
    chk("rst:det_hit", det_hit, 0);
    chk("rst:cfg_err", cfg_err, 0);
    chk("rst:count", res_count, 0);
    chk("rst:ovf", res_overflow, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

    // Illegal lengths in IDLE are rejected; config stays at 1'b1 / len 1.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_pattern = 8'hFF; cfg_len = (k == 0) ? 4'd0 : 4'd9;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      chk("badlen:err_pulse", cfg_err, 1);
      @(posedge clk); #1;
      chk("badlen:err_clear", cfg_err, 0);
    end
    v = tbl[6]; v.cfg = 1'b0;
    run_frame(v, "badlen_frame");

    // Write during SHIFT is rejected; 6C under len1/pattern 1 has four ones.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h6C; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_pattern = 8'h07; cfg_len = 4'd3;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    chk("shiftcfg:err_pulse", cfg_err, 1);
    cyc = 0;
    while (!res_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("shiftcfg:valid", res_valid, 1);
    chk("shiftcfg:count", res_count, 4);
    close_frame("shiftcfg");

    // Reset mid-frame aborts and restores the default detector.
    @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = 8'h07; cfg_len = 4'd3;
    in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst:res_valid", res_valid, 0);
    chk("midrst:in_ready", in_ready, 1);
    chk("midrst:busy", busy, 0);
    chk("midrst:count", res_count, 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      chk("midrst:no_result", res_valid, 0);
    end
    run_frame(tbl[0], "postrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
